// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the snake-game tile memory arbiter.
//   - grid geometry and visible-area limits
//   - 2-bit tile codes
//   - arbiter FSM state and write-buffer entry types
//   - tile_addr(): ty*40 + tx using shifts and adds only
package vram_arbiter_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int TILE_SHIFT = 4;
  localparam int H_VIS      = 640;
  localparam int V_VIS      = 480;
  localparam int NUM_TILES  = GRID_W * GRID_H;
  localparam int ADDR_W     = 11;

  localparam logic [1:0] TILE_EMPTY = 2'd0;
  localparam logic [1:0] TILE_SNAKE = 2'd1;
  localparam logic [1:0] TILE_FOOD  = 2'd2;
  localparam logic [1:0] TILE_WALL  = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        code;
  } wr_ent_t;

  // ty*40 + tx == ty*32 + ty*8 + tx
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [4:0] ty,
                                                  input logic [5:0] tx);
    return {1'b0, ty, 5'b0} + {3'b0, ty, 3'b0} + {5'b0, tx};
  endfunction

endpackage

// File: rtl/vram_arbiter_tile_ram.sv
// 1200 x 2-bit single-port synchronous tile RAM.
//   clk      : clock
//   re_i     : read enable, rdata_o updates on the next edge
//   we_i     : write enable
//   addr_i   : tile address (0..1199)
//   wdata_i  : tile code to write
//   rdata_o  : registered read data
module vram_arbiter_tile_ram
  import vram_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        wdata_i,
  output logic [1:0]        rdata_o
);

  logic [1:0] mem_q [NUM_TILES];
  logic [1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// Tile memory owner for the snake game: arbitrates one single-port tile RAM
// between the VGA scan-out reader (always first) and the game logic
// (single writes and full-grid clears, which only use blanking cycles).
// Each stored 2-bit code is mapped to a 12-bit RGB word on Din.
//   clk, rst          : clock, synchronous active-high reset
//   row, col, rdn     : VGA pixel position and active-low read strobe
//   Din               : RGB to VGA, 2 cycles after the read strobe
//   wr_valid/wr_ready : game write handshake, wr_x/wr_y/wr_code payload
//   clr_req, clr_code : one-cycle request to fill the grid with clr_code
//   busy              : clear running or write buffer occupied
module vram_arbiter #(
  parameter int          GRID_W    = 40,
  parameter int          GRID_H    = 30,
  parameter logic [11:0] COL_BG    = 12'h000,
  parameter logic [11:0] COL_SNAKE = 12'h0F0,
  parameter logic [11:0] COL_FOOD  = 12'hF00,
  parameter logic [11:0] COL_WALL  = 12'h888
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  row,
  input  logic [9:0]  col,
  input  logic        rdn,
  output logic [11:0] Din,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_x,
  input  logic [4:0]  wr_y,
  input  logic [1:0]  wr_code,
  input  logic        clr_req,
  input  logic [1:0]  clr_code,
  output logic        busy
);
  import vram_arbiter_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TILES - 1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [1:0]        clr_code_q, clr_code_d;
  logic              buf_full_q, buf_full_d;
  wr_ent_t           buf_q, buf_d;
  logic              rd_vld_q;
  logic [11:0]       din_q;

  logic              rd_en;
  logic              wr_in_range;
  logic [ADDR_W-1:0] rd_addr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_wdata;
  logic [1:0]        ram_rdata;

  function automatic logic [11:0] palette(input logic [1:0] code);
    case (code)
      TILE_EMPTY: return COL_BG;
      TILE_SNAKE: return COL_SNAKE;
      TILE_FOOD:  return COL_FOOD;
      default:    return COL_WALL;
    endcase
  endfunction

  assign rd_en       = ~rdn & (row < 9'(V_VIS)) & (col < 10'(H_VIS));
  assign rd_addr     = tile_addr(row[8:4], col[9:4]);
  assign wr_in_range = (wr_x < 6'(GRID_W)) & (wr_y < 5'(GRID_H));

  assign wr_ready = ~rst & ~buf_full_q & (state_q == IDLE) & ~clr_req;
  assign busy     = (state_q == CLEAR) | buf_full_q;
  assign Din      = din_q;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_code_d = clr_code_q;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    ram_we     = 1'b0;
    ram_addr   = rd_addr;
    ram_wdata  = clr_code_q;

    // The buffer can only hold an entry left over from IDLE, so draining it
    // ahead of the clear guarantees it lands before the first clear write.
    if (rd_en) begin
      ram_addr = rd_addr;
    end else if (buf_full_q) begin
      ram_we     = 1'b1;
      ram_addr   = buf_q.addr;
      ram_wdata  = buf_q.code;
      buf_full_d = 1'b0;
    end else if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_cnt_q;
      ram_wdata = clr_code_q;
      if (clr_cnt_q == LAST_ADDR) begin
        state_d   = IDLE;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end

    // Out-of-range writes complete the handshake but never fill the buffer.
    if (wr_valid & wr_ready & wr_in_range) begin
      buf_full_d = 1'b1;
      buf_d.addr = tile_addr(wr_y, wr_x);
      buf_d.code = wr_code;
    end

    if ((state_q == IDLE) & clr_req) begin
      state_d    = CLEAR;
      clr_cnt_d  = '0;
      clr_code_d = clr_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      clr_code_q <= TILE_EMPTY;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      rd_vld_q   <= 1'b0;
      din_q      <= 12'h000;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_code_q <= clr_code_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      rd_vld_q   <= rd_en;
      din_q      <= rd_vld_q ? palette(ram_rdata) : 12'h000;
    end
  end

  // A reset landing mid-clear must not write the next clear address.
  vram_arbiter_tile_ram u_tile_ram (
    .clk     (clk),
    .re_i    (rd_en),
    .we_i    (ram_we & ~rst),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

endmodule
